// File: rtl/draw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : draw_arbiter
//  Purpose  : Round-robin burst arbiter that shares the single VGA plot port
//             between NREQ pixel sources. A requester holds req high for a
//             whole burst; the granted source's pixel stream is registered
//             onto x/y/colour/writeEn, and off-screen pixels are clipped.
//  Revision : 1.0  initial release
//
//  Optional feature macro: DRAW_ARB_TIMEOUT_EN
//    defined   -> bursts are limited to MAX_BURST owned cycles. When the limit
//                 is reached the grant is forcibly released and timeout
//                 pulses for one cycle.
//    undefined -> bursts are unbounded and timeout is always 0.
//
//  Ports
//    clk       in   1        system clock
//    resetn    in   1        asynchronous active-low reset
//    req       in   NREQ     burst request, held for the whole burst
//    px_valid  in   NREQ     pixel strobe per requester
//    x_bus     in   10*NREQ  x of requester i at [10*i+:10]
//    y_bus     in   10*NREQ  y of requester i at [10*i+:10]
//    col_bus   in   3*NREQ   colour of requester i at [3*i+:3]
//    grant     out  NREQ     one-hot registered grant
//    busy      out  1        arbiter is arbitrating, owned or releasing
//    x, y      out  10       registered plot coordinates
//    colour    out  3        registered plot colour
//    writeEn   out  1        registered plot strobe
//    timeout   out  1        one-cycle pulse on forced release
// ============================================================================
module draw_arbiter #(
  parameter int NREQ      = 4,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int MAX_BURST = 4096
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      px_valid,
  input  logic [10*NREQ-1:0]   x_bus,
  input  logic [10*NREQ-1:0]   y_bus,
  input  logic [3*NREQ-1:0]    col_bus,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic [9:0]           x,
  output logic [9:0]           y,
  output logic [2:0]           colour,
  output logic                 writeEn,
  output logic                 timeout
);

  // Index width; kept at least 1 bit so NREQ=1 still has a legal vector.
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [9:0] c_scr_w = 10'(SCREEN_W);
  localparam logic [9:0] c_scr_h = 10'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_OWN  = 2'd2,
    S_REL  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   w_rr_d;
  logic [PW-1:0]   w_owner_d;
  logic [NREQ-1:0] w_grant_d;

  logic [PW-1:0]   w_win;
  logic            w_found;
  logic [NREQ-1:0] w_onehot;
  logic            w_owner_req;
  logic            w_force;

  logic            w_acc;
  logic            w_onscr;
  logic [9:0]      w_x;
  logic [9:0]      w_y;
  logic [2:0]      w_c;

  // --------------------------------------------------------------------------
  // Round-robin search: first set req bit at or after r_rr_ptr, wrapping.
  // --------------------------------------------------------------------------
  always_comb begin
    int v_idx;
    w_win   = '0;
    w_found = 1'b0;
    v_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && req[v_idx]) begin
        w_found = 1'b1;
        w_win   = PW'(v_idx);
      end
    end
  end

  assign w_onehot    = NREQ'(1) << w_win;
  // grant is one-hot on the owner while owned, so this selects req[owner].
  assign w_owner_req = |(req & grant);
  assign busy        = (r_state != S_IDLE);

  // --------------------------------------------------------------------------
  // Optional burst-length limit.
  // --------------------------------------------------------------------------
`ifdef DRAW_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0] r_burst_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_burst_cnt <= '0;
    end else if (r_state == S_ARB) begin
      r_burst_cnt <= '0;
    end else if (r_state == S_OWN) begin
      r_burst_cnt <= r_burst_cnt + CW'(1);
    end
  end

  // Count starts at 0 in the first owned cycle, so MAX_BURST-1 marks the
  // last permitted one.
  assign w_force = (r_state == S_OWN) && (r_burst_cnt == CW'(MAX_BURST - 1));
`else
  logic [31:0] w_unused_max;
  assign w_unused_max = 32'(MAX_BURST);
  assign w_force      = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and next grant / pointer values
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_grant_d = grant;
    w_rr_d    = r_rr_ptr;
    w_owner_d = r_owner;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_next = S_ARB;
        end
      end
      S_ARB: begin
        if (w_found) begin
          w_next    = S_OWN;
          w_grant_d = w_onehot;
          w_owner_d = w_win;
        end else begin
          w_next    = S_IDLE;
          w_grant_d = '0;
        end
      end
      S_OWN: begin
        // Grant drops on entry to S_REL so nothing is accepted in the
        // dead cycle; the pixel of the final owned cycle still lands.
        if (!w_owner_req || w_force) begin
          w_next    = S_REL;
          w_grant_d = '0;
        end
      end
      S_REL: begin
        w_next    = S_IDLE;
        w_grant_d = '0;
        if (int'(r_owner) >= NREQ - 1) begin
          w_rr_d = '0;
        end else begin
          w_rr_d = r_owner + PW'(1);
        end
      end
      default: begin
        w_next    = S_IDLE;
        w_grant_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pixel path: mux the granted lane, clip against the screen.
  // --------------------------------------------------------------------------
  always_comb begin
    w_x = '0;
    w_y = '0;
    w_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        w_x = w_x | x_bus[10*i +: 10];
        w_y = w_y | y_bus[10*i +: 10];
        w_c = w_c | col_bus[3*i +: 3];
      end
    end
  end

  assign w_acc   = |(grant & px_valid);
  assign w_onscr = (w_x < c_scr_w) && (w_y < c_scr_h);

  // --------------------------------------------------------------------------
  // Registered outputs and arbitration bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant    <= '0;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      timeout  <= 1'b0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      writeEn  <= 1'b0;
    end else begin
      grant    <= w_grant_d;
      r_rr_ptr <= w_rr_d;
      r_owner  <= w_owner_d;
      timeout  <= w_force;
      if (w_acc) begin
        x       <= w_x;
        y       <= w_y;
        colour  <= w_c;
        writeEn <= w_onscr;
      end else begin
        writeEn <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_draw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_draw_arbiter
//  Purpose  : Self-checking bench for draw_arbiter: a table of directed
//             vectors, hand-written multi-cycle sequences (reset, contention,
//             fairness, optional timeout) and a randomized run against a
//             behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_draw_arbiter;

  localparam int N  = 4;
  localparam int MB = 8;
`ifdef DRAW_ARB_TIMEOUT_EN
  localparam bit TB_TO = 1'b1;
`else
  localparam bit TB_TO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic [N-1:0]  req;
  logic [N-1:0]  pv;
  logic [39:0]   xb;
  logic [39:0]   yb;
  logic [11:0]   cb;
  logic [N-1:0]  grant;
  logic          busy;
  logic [9:0]    x;
  logic [9:0]    y;
  logic [2:0]    colour;
  logic          we;
  logic          to;

  int n_vec = 0;
  int n_err = 0;

  draw_arbiter #(
    .NREQ(N), .SCREEN_W(160), .SCREEN_H(120), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .px_valid(pv),
    .x_bus(xb), .y_bus(yb), .col_bus(cb),
    .grant(grant), .busy(busy), .x(x), .y(y), .colour(colour),
    .writeEn(we), .timeout(to)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge; new inputs are
  // driven at the same point and take effect at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All lanes carry an on-screen decoy pixel (1,1,7); lane i carries the data.
  task automatic set_lane(input int i, input logic [9:0] px, input logic [9:0] py,
                          input logic [2:0] pc);
    for (int k = 0; k < N; k++) begin
      xb[10*k +: 10] = 10'd1;
      yb[10*k +: 10] = 10'd1;
      cb[3*k +: 3]   = 3'd7;
    end
    xb[10*i +: 10] = px;
    yb[10*i +: 10] = py;
    cb[3*i +: 3]   = pc;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req    = '0;
    pv     = '0;
    set_lane(0, 10'd0, 10'd0, 3'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic wait_grant(input logic [N-1:0] exp, input string nm);
    int n = 0;
    while (grant == '0 && n < 20) begin
      tick();
      n++;
    end
    chk(nm, 32'(grant), 32'(exp));
  endtask

  // Owner of lane 'lane' (already granted) plots two pixels, drops req to
  // 'next_req' with no pixel, and the next grant must be 'exp_next' after a
  // grant-less gap of REL, IDLE, ARB with writeEn low throughout.
  task automatic burst_release(input int lane, input logic [N-1:0] next_req,
                               input logic [N-1:0] exp_next, input string nm);
    int gap = 0;
    pv = '0;
    pv[lane] = 1'b1;
    set_lane(lane, 10'd20, 10'd30, 3'd2);
    tick();
    tick();
    chk({nm, "_we"}, 32'(we), 32'd1);
    pv  = '0;
    req = next_req;
    tick();
    while (grant == '0 && gap < 10) begin
      chk({nm, "_gap_we"}, 32'(we), 32'd0);
      gap++;
      tick();
    end
    chk({nm, "_gap"}, 32'(gap), 32'd3);
    chk({nm, "_next"}, 32'(grant), 32'(exp_next));
  endtask

  // --------------------------------------------------------------------------
  // Reference model: who owns the port, whether we are arbitrating or in the
  // release gap, and where the round-robin search starts.
  // --------------------------------------------------------------------------
  int           m_owner, m_rr, m_len;
  bit           m_arb, m_rel;
  logic [N-1:0] m_grant;
  logic         m_busy, m_we, m_to;
  logic [9:0]   m_x, m_y;
  logic [2:0]   m_c;

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_len = 0; m_arb = 0; m_rel = 0;
    m_grant = '0; m_busy = 0; m_we = 0; m_to = 0;
    m_x = '0; m_y = '0; m_c = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] v);
    bit holds;
    holds = (m_owner >= 0) && !m_rel;
    m_we = 1'b0;
    if (holds && v[m_owner]) begin
      m_x  = xb[10*m_owner +: 10];
      m_y  = yb[10*m_owner +: 10];
      m_c  = cb[3*m_owner +: 3];
      m_we = (m_x < 10'd160) && (m_y < 10'd120);
    end
    m_to = 1'b0;
    if (m_rel) begin
      m_rr    = (m_owner + 1) % N;
      m_owner = -1;
      m_rel   = 0;
    end else if (m_owner >= 0) begin
      m_len++;
      if (!r[m_owner] || (TB_TO && m_len == MB)) begin
        m_rel = 1;
        m_to  = TB_TO && (m_len == MB);
      end
    end else if (m_arb) begin
      m_arb = 0;
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && r[(m_rr + k) % N]) begin
          m_owner = (m_rr + k) % N;
          m_len   = 0;
        end
      end
    end else if (|r) begin
      m_arb = 1;
    end
    m_grant = ((m_owner >= 0) && !m_rel) ? N'(1) << m_owner : '0;
    m_busy  = m_arb || (m_owner >= 0);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table (applied straight after reset; rr pointer at 0).
  // Lane 1 carries (px,py,pc); other lanes carry the decoy (1,1,7).
  // --------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] pv;
    logic [9:0]   px, py;
    logic [2:0]   pc;
    logic [N-1:0] e_grant;
    logic         e_busy, e_we;
    logic [9:0]   e_x, e_y;
    logic [2:0]   e_c;
  } vec_t;

  vec_t tv[11];

  initial begin
    logic [N-1:0] r_rand;
    int cnt;

    tv[0]  = '{4'b0010, 4'b0000, 10'd0,   10'd0,   3'd0, 4'b0000, 1'b1, 1'b0, 10'd0,   10'd0,   3'd0};
    tv[1]  = '{4'b0010, 4'b0000, 10'd0,   10'd0,   3'd0, 4'b0010, 1'b1, 1'b0, 10'd0,   10'd0,   3'd0};
    tv[2]  = '{4'b0010, 4'b0010, 10'd5,   10'd7,   3'd4, 4'b0010, 1'b1, 1'b1, 10'd5,   10'd7,   3'd4};
    tv[3]  = '{4'b0010, 4'b0010, 10'd5,   10'd7,   3'd4, 4'b0010, 1'b1, 1'b1, 10'd5,   10'd7,   3'd4};
    tv[4]  = '{4'b0010, 4'b0010, 10'd5,   10'd7,   3'd4, 4'b0010, 1'b1, 1'b1, 10'd5,   10'd7,   3'd4};
    tv[5]  = '{4'b0010, 4'b0010, 10'd159, 10'd119, 3'd1, 4'b0010, 1'b1, 1'b1, 10'd159, 10'd119, 3'd1};
    tv[6]  = '{4'b0010, 4'b0010, 10'd160, 10'd10,  3'd2, 4'b0010, 1'b1, 1'b0, 10'd160, 10'd10,  3'd2};
    tv[7]  = '{4'b0010, 4'b0010, 10'd3,   10'd120, 3'd3, 4'b0010, 1'b1, 1'b0, 10'd3,   10'd120, 3'd3};
    tv[8]  = '{4'b0010, 4'b1000, 10'd50,  10'd50,  3'd5, 4'b0010, 1'b1, 1'b0, 10'd3,   10'd120, 3'd3};
    tv[9]  = '{4'b0000, 4'b0010, 10'd10,  10'd20,  3'd5, 4'b0000, 1'b1, 1'b1, 10'd10,  10'd20,  3'd5};
    tv[10] = '{4'b0000, 4'b0000, 10'd0,   10'd0,   3'd0, 4'b0000, 1'b0, 1'b0, 10'd10,  10'd20,  3'd5};

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_pix",   32'({we, x, y, colour}), 32'd0);
    chk("rst_to",    32'(to),    32'd0);

    // ---------------- table ----------------
    for (int i = 0; i < 11; i++) begin
      req = tv[i].req;
      pv  = tv[i].pv;
      set_lane(1, tv[i].px, tv[i].py, tv[i].pc);
      tick();
      chk($sformatf("tv%0d_grant", i), 32'(grant), 32'(tv[i].e_grant));
      chk($sformatf("tv%0d_busy", i),  32'(busy),  32'(tv[i].e_busy));
      chk($sformatf("tv%0d_we", i),    32'(we),    32'(tv[i].e_we));
      chk($sformatf("tv%0d_xyc", i),   32'({x, y, colour}),
          32'({tv[i].e_x, tv[i].e_y, tv[i].e_c}));
    end

    // ---------------- reset mid-burst (rr pointer is now 2) ----------------
    req = 4'b0100;
    wait_grant(4'b0100, "mid_grant");
    pv = 4'b0100;
    set_lane(2, 10'd40, 10'd41, 3'd6);
    tick();
    chk("mid_we", 32'(we), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_busy",  32'(busy),  32'd0);
    chk("mid_rst_pix",   32'({we, x, y, colour}), 32'd0);
    chk("mid_rst_to",    32'(to),    32'd0);
    req = '0;
    pv  = '0;
    @(posedge clk);
    #1 resetn = 1'b1;
    req = 4'b0110;
    wait_grant(4'b0010, "rst_rr_ptr");

    // ---------------- contention 0,1,3 ----------------
    do_reset();
    req = 4'b1011;
    wait_grant(4'b0001, "cont_first");
    burst_release(0, 4'b1010, 4'b0010, "cont_0to1");
    burst_release(1, 4'b1000, 4'b1000, "cont_1to3");

    // ---------------- fairness: re-request loses to a pending one ----------
    do_reset();
    req = 4'b0101;
    wait_grant(4'b0001, "fair_first");
    req = 4'b0100;
    tick();
    chk("fair_rel_grant", 32'(grant), 32'd0);
    req = 4'b0101;
    tick();
    wait_grant(4'b0100, "fair_second");
    req = 4'b0001;
    tick();
    wait_grant(4'b0001, "fair_third");

`ifdef DRAW_ARB_TIMEOUT_EN
    // ---------------- forced release after MB owned cycles ----------------
    do_reset();
    req = 4'b0100;
    wait_grant(4'b0100, "to_grant");
    req = 4'b1100;
    cnt = 0;
    while (grant == 4'b0100 && cnt < 40) begin
      chk("to_early", 32'(to), 32'd0);
      cnt++;
      tick();
    end
    chk("to_len", 32'(cnt), 32'(MB));
    chk("to_pulse", 32'(to), 32'd1);
    tick();
    chk("to_pulse_end", 32'(to), 32'd0);
    wait_grant(4'b1000, "to_next");
`endif

    // ---------------- randomized run against the model ----------------
    do_reset();
    model_reset();
    r_rand = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) r_rand[i] = ~r_rand[i];
        xb[10*i +: 10] = 10'($urandom_range(200));
        yb[10*i +: 10] = 10'($urandom_range(150));
        cb[3*i +: 3]   = 3'($urandom_range(7));
      end
      req = r_rand;
      pv  = N'($urandom);
      tick();
      model_edge(req, pv);
      chk("rnd_grant", 32'(grant), 32'(m_grant));
      chk("rnd_busy",  32'(busy),  32'(m_busy));
      chk("rnd_we",    32'(we),    32'(m_we));
      chk("rnd_to",    32'(to),    32'(m_to));
      chk("rnd_xyc",   32'({x, y, colour}), 32'({m_x, m_y, m_c}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
